// File: rtl/ifu_fetch_buf_if.sv
// ---------------------------------------------------------------------------
// ifu_fetch_buf_if
//
// Purpose: bundles the three handshakes around the fetch buffer.
//   - fetch request from the IFU (PC side)
//   - single-word read port towards instruction memory
//   - instruction/PC/fault stream towards the decoder
//
// Signal names keep the buffer's point of view (_i = into the buffer,
// _o = out of the buffer) so they line up with the block's port list.
//
// Modports:
//   slave  - the fetch buffer itself
//   master - the environment around it (IFU, memory and decoder side)
// ---------------------------------------------------------------------------
interface ifu_fetch_buf_if #(
    parameter int XLEN = 32
);
    // Fetch request from the IFU
    logic            fetch_vld_i;
    logic            fetch_rdy_o;
    logic [XLEN-1:0] fetch_addr_i;
    logic            flush_i;

    // Instruction memory read port
    logic            mem_rd_en_o;
    logic [XLEN-1:0] mem_addr_o;
    logic            mem_rd_vld_i;
    logic [XLEN-1:0] mem_rd_data_i;

    // Decoder side
    logic            inst_vld_o;
    logic            inst_rdy_i;
    logic [XLEN-1:0] inst_data_o;
    logic [XLEN-1:0] inst_pc_o;
    logic            inst_err_o;

    modport slave (
        input  fetch_vld_i,
        input  fetch_addr_i,
        input  flush_i,
        input  mem_rd_vld_i,
        input  mem_rd_data_i,
        input  inst_rdy_i,
        output fetch_rdy_o,
        output mem_rd_en_o,
        output mem_addr_o,
        output inst_vld_o,
        output inst_data_o,
        output inst_pc_o,
        output inst_err_o
    );

    modport master (
        output fetch_vld_i,
        output fetch_addr_i,
        output flush_i,
        output mem_rd_vld_i,
        output mem_rd_data_i,
        output inst_rdy_i,
        input  fetch_rdy_o,
        input  mem_rd_en_o,
        input  mem_addr_o,
        input  inst_vld_o,
        input  inst_data_o,
        input  inst_pc_o,
        input  inst_err_o
    );
endinterface

// File: rtl/ifu_fetch_buf.sv
// ---------------------------------------------------------------------------
// ifu_fetch_buf
//
// Purpose: consumer end of the IFU program-counter interface. Accepts one
// fetch request at a time, issues a single-word read to instruction memory,
// and queues {pc, instruction, fault} entries in a small FIFO for decode.
// A flush empties the FIFO and drops any read still in flight.
//
// Ports:
//   clk_i    - clock
//   rst_n_i  - asynchronous active-low reset
//   bus      - ifu_fetch_buf_if.slave: fetch request, memory read port and
//              decoder stream (see the interface file for the signal list)
//
// Parameters:
//   XLEN   - address / instruction width
//   DEPTH  - FIFO entries (power of two, >= 2)
//
// Optional feature (macro IFU_FETCH_MISALIGN_CHK_EN):
//   defined   - a fetch with addr[1:0]!=0 issues no read and immediately
//               queues a fault entry {pc=addr, data=0, err=1}.
//   undefined - addr[1:0] are ignored for the read; inst_err_o is tied 0
//               and no fault bit is stored.
// ---------------------------------------------------------------------------
module ifu_fetch_buf #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    ifu_fetch_buf_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;

    logic [CW-1:0]   count_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;

    logic [XLEN-1:0] pc_reg;          // PC of the read in flight
    logic            mem_rd_en_reg;
    logic [XLEN-1:0] mem_addr_reg;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
`ifdef IFU_FETCH_MISALIGN_CHK_EN
    logic            err_mem  [DEPTH];
`endif

    logic            fetch_rdy;
    logic            accept;
    logic            misalign;
    logic            issue;
    logic            push_en;
    logic [XLEN-1:0] push_pc;
    logic [XLEN-1:0] push_data;
    logic            push_err;
    logic            pop_en;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // A response in WAIT always returns to IDLE; whether it is kept or
    // dropped is decided by push_en. A flush without a response parks in
    // DROP until the outstanding read comes back.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (issue) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.mem_rd_vld_i) begin
                    state_next = ST_IDLE;
                end else if (bus.flush_i) begin
                    state_next = ST_DROP;
                end
            end
            ST_DROP: begin
                if (bus.mem_rd_vld_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs / datapath controls
    // fetch_rdy requires a free slot, which reserves room for the response,
    // so a push can never find the FIFO full.
    // -----------------------------------------------------------------------
    always_comb begin
        fetch_rdy = (state_reg == ST_IDLE) && (count_reg < DEPTH_C) && !bus.flush_i;
        accept    = bus.fetch_vld_i && fetch_rdy;
`ifdef IFU_FETCH_MISALIGN_CHK_EN
        misalign  = accept && (bus.fetch_addr_i[1:0] != 2'b00);
`else
        misalign  = 1'b0;
`endif
        issue     = accept && !misalign;

        push_en   = 1'b0;
        push_pc   = pc_reg;
        push_data = bus.mem_rd_data_i;
        push_err  = 1'b0;

        if ((state_reg == ST_WAIT) && bus.mem_rd_vld_i && !bus.flush_i) begin
            push_en = 1'b1;
        end

        // A misaligned fetch is only possible in IDLE, so it never collides
        // with a memory response push. Flush blocks accept and thus wins.
        if (misalign) begin
            push_en   = 1'b1;
            push_pc   = bus.fetch_addr_i;
            push_data = '0;
            push_err  = 1'b1;
        end

        pop_en = (count_reg != '0) && bus.inst_rdy_i;
    end

    // -----------------------------------------------------------------------
    // Memory read issue: one-cycle strobe, address held until next issue
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_rd_en_reg <= 1'b0;
            mem_addr_reg  <= '0;
            pc_reg        <= '0;
        end else begin
            mem_rd_en_reg <= issue;
            if (issue) begin
                mem_addr_reg <= {bus.fetch_addr_i[XLEN-1:2], 2'b00};
                pc_reg       <= bus.fetch_addr_i;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers and occupancy
    // Flush clears occupancy; a pop in the same cycle is meaningless and a
    // push cannot happen (push_en is gated by flush).
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (bus.flush_i) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FIFO storage: one register set per entry so reset can clear it
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    pc_mem[gi]   <= '0;
                    data_mem[gi] <= '0;
                end else if (push_en && (wr_ptr_reg == AW'(gi))) begin
                    pc_mem[gi]   <= push_pc;
                    data_mem[gi] <= push_data;
                end
            end
`ifdef IFU_FETCH_MISALIGN_CHK_EN
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    err_mem[gi] <= 1'b0;
                end else if (push_en && (wr_ptr_reg == AW'(gi))) begin
                    err_mem[gi] <= push_err;
                end
            end
`endif
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.fetch_rdy_o = fetch_rdy;
    assign bus.mem_rd_en_o = mem_rd_en_reg;
    assign bus.mem_addr_o  = mem_addr_reg;
    assign bus.inst_vld_o  = (count_reg != '0);
    assign bus.inst_data_o = data_mem[rd_ptr_reg];
    assign bus.inst_pc_o   = pc_mem[rd_ptr_reg];
`ifdef IFU_FETCH_MISALIGN_CHK_EN
    assign bus.inst_err_o  = err_mem[rd_ptr_reg];
`else
    assign bus.inst_err_o  = 1'b0;
    // push_err only feeds storage when the fault bit exists
    logic unused_push_err;
    assign unused_push_err = push_err;
`endif

endmodule

// File: doc/ifu_fetch_buf.md
Name: ifu_fetch_buf

Overview:
- Consumer end of the IFU program-counter interface.
- Accepts fetch requests (PC) from the fetch unit, issues single-word reads to the instruction memory port, and buffers the returned instructions with their PC in a small FIFO for the decode stage.
- Supports pipeline flush, which discards buffered entries and any in-flight memory read.
- Sits between ifu and the decoder/IDU.

Parameters:
- XLEN, 32, address/instruction data width.
- DEPTH, 2, FIFO entries (power of two, >= 2).

Ports:
- clk_i  input  1  clock
- rst_n_i  input  1  asynchronous active-low reset
- fetch_vld_i  input  1  fetch request valid
- fetch_rdy_o  output  1  fetch request accepted when high together with fetch_vld_i
- fetch_addr_i  input  XLEN  PC to fetch (driven from pc_data_o)
- flush_i  input  1  discard all buffered and in-flight fetches
- mem_rd_en_o  output  1  memory read strobe, one cycle per read
- mem_addr_o  output  XLEN  word-aligned read address
- mem_rd_vld_i  input  1  memory read data valid
- mem_rd_data_i  input  XLEN  memory read data
- inst_vld_o  output  1  head entry valid
- inst_rdy_i  input  1  decoder consumes head entry
- inst_data_o  output  XLEN  head instruction
- inst_pc_o  output  XLEN  head PC
- inst_err_o  output  1  head entry misaligned-fetch fault

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_n_i is asynchronous, active-low.
- Reset values:
  - state IDLE; FIFO count/pointers 0; storage 0.
  - mem_rd_en_o=0; mem_addr_o=0.
  - inst_vld_o=0; inst_data_o=0; inst_pc_o=0; inst_err_o=0.
- Reset mid-read: the in-flight response is forgotten; mem_rd_vld_i is ignored while in IDLE.
- FSM states: IDLE, WAIT, DROP.
- fetch_rdy_o:
  - Combinational: fetch_rdy_o = (state==IDLE) && (count<DEPTH) && !flush_i.
  - This reserves a FIFO slot, so a push can never overflow.
- Accept (fetch_vld_i && fetch_rdy_o at edge N):
  - Latch the address and go to WAIT.
  - In cycle N+1: mem_rd_en_o=1 (registered, exactly one cycle) and mem_addr_o={addr[XLEN-1:2],2'b00}.
  - mem_addr_o holds its value until the next accept.
- WAIT:
  - mem_rd_vld_i is sampled starting in the cycle mem_rd_en_o is high, so a zero-wait memory works.
  - On mem_rd_vld_i: push {pc, data, err=0} and go to IDLE.
  - Minimum latency accept→inst_vld_o is 2 cycles.
  - Zero-wait back-to-back issue: a new request can be accepted in the cycle after the push, so there is one issue every 2 cycles.
- DROP:
  - Wait for mem_rd_vld_i, discard the data, go to IDLE.
  - mem_rd_vld_i arriving in IDLE is ignored.
- FIFO:
  - inst_vld_o = count!=0; head fields are driven from the read pointer.
  - Pop on inst_vld_o && inst_rdy_i.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- Flush (flush_i=1 at an edge):
  - count and pointers go to 0, so inst_vld_o=0 in the next cycle. A same-cycle pop or push is discarded.
  - State WAIT with mem_rd_vld_i=0: go to DROP.
  - State WAIT with mem_rd_vld_i=1: data discarded, go to IDLE.
  - Flush held in DROP: stay in DROP.
  - mem_rd_en_o is never suppressed once registered; the read completes and is dropped.
- Address width: only bits [1:0] are cleared; there is no wrap arithmetic.

Optional Feature:
- Macro: IFU_FETCH_MISALIGN_CHK_EN.
- Defined:
  - An accepted fetch with fetch_addr_i[1:0]!=0 issues no memory read and stays in IDLE.
  - It pushes {pc=fetch_addr_i, data=0, err=1} at the accept edge; inst_vld_o rises 1 cycle after accept.
  - A flush in the same cycle wins, and no entry is pushed.
- Not defined:
  - Address bits [1:0] are ignored (aligned as above).
  - inst_err_o is constant 0 and the err storage bit is removed.

Test Plan:
- Reset then single fetch, addr 0x0000_0104; memory responds in the same cycle as mem_rd_en_o with 0x0000_0013 -> mem_addr_o=0x0000_0104; inst_vld_o=1 two cycles after accept with inst_pc_o=0x0000_0104 and inst_data_o=0x0000_0013.
- inst_rdy_i=0; fetches 0x100, 0x104, 0x108 offered, memory 3-cycle latency -> two entries buffered, fetch_rdy_o=0 with count=2; raising inst_rdy_i drains 0x100 then 0x104 and the third fetch is then accepted; order preserved.
- Fetch 0x200 accepted; flush_i pulsed one cycle while in WAIT, memory returns 0xDEAD_BEEF two cycles later -> data discarded, inst_vld_o stays 0, fetch_rdy_o=1 only after the response arrives.
- Full FIFO (count=2) plus flush_i together with inst_rdy_i=1 -> inst_vld_o=0 next cycle, count=0, no pop observed.
- With IFU_FETCH_MISALIGN_CHK_EN defined, fetch 0x0000_0302 -> no mem_rd_en_o; inst_vld_o=1, inst_err_o=1, inst_pc_o=0x0000_0302, inst_data_o=0 one cycle later. Without the macro -> mem_addr_o=0x0000_0300, inst_err_o=0.
- rst_n_i asserted while in WAIT, mem_rd_vld_i arrives after release -> response ignored; all outputs remain at reset values.
